jtag_dr_bridge: RTL and testbench
=================================

// Module: jtag_dr_bridge
// PURPOSE
// - USER-IR data-register endpoint behind the BSCAN primitive, in the tck domain.
// - Deserializes 8-bit DR scans (LSB first) into a byte stream for the solver pipeline.
// - Serializes the solver result back out on tdo during any DR scan.
// - Input scan path: byte-per-scan. Output scan path: result readback.
// PARAMETERS
// - RESULT_WIDTH  16  width of the result captured into the readback chain
// - FIFO_DEPTH    16  byte FIFO entries; power of 2, >= 2
// PORTS
// - tck                 in   1   BSCAN TCK; sole clock, all logic on posedge
// - test_logic_reset_n  in   1   synchronous active-low reset (parent drives ~test_logic_reset)
// - ir_is_user          in   1   IR holds the USER instruction; gates capture/shift/update
// - capture_dr          in   1   TAP in Capture-DR
// - shift_dr            in   1   TAP in Shift-DR
// - update_dr           in   1   TAP in Update-DR
// - tdi                 in   1   scan data in
// - tdo                 out  1   scan data out
// - result              in   RESULT_WIDTH  solver result, sampled at capture
// - out_valid           out  1   FIFO non-empty
// - out_data            out  8   FIFO head byte
// - out_ready           in   1   consumer pops head when out_valid & out_ready
// - overflow            out  1   sticky: a byte was dropped on full FIFO
// BEHAVIOUR
// Reset
// - test_logic_reset_n=0 at posedge: FIFO emptied, bit_cnt=0, byte_sr=0, rb_sr=0, overflow=0.
// - Every output reads 0 the following cycle; out_data=0 while empty.
// - Reset overrides any scan in progress; a partial byte is discarded.
// Gating
// - capture_dr, shift_dr and update_dr are ignored while ir_is_user=0.
// - tdo=0 while ir_is_user=0.
// Capture (capture_dr & ir_is_user)
// - rb_sr <= result (zero-extended to the chain width).
// - bit_cnt <= 0.
// Shift (shift_dr & ir_is_user), once per posedge
// - byte_sr <= {tdi, byte_sr[7:1]}.
// - rb_sr <= {1'b0, rb_sr[W-1:1]}.
// - bit_cnt saturates at 255.
// - tdo = rb_sr[0]: registered, no comb path from tdi.
// - The first result bit is valid on tdo in the cycle after capture.
// Update (update_dr & ir_is_user)
// - bit_cnt==8: push byte_sr to FIFO.
// - bit_cnt!=8 (readback scans, aborted scans): no push, no side effects.
// - Capture->push latency: 10 tck (1 capture + 8 shift + exit1); the byte is visible at out_* next cycle.
// FIFO
// - First-word fall-through: out_data is valid with out_valid.
// - Push when full with no same-cycle pop: byte dropped, overflow<=1 (sticky until reset), FIFO contents unchanged.
// - Push when full with a same-cycle pop: push accepted, occupancy unchanged.
// - Pop on empty: ignored.
// - Pointers wrap modulo FIFO_DEPTH.
// - Extra occupancy bit distinguishes full from empty.
// CONFIGURATION
// - JTAG_DR_BRIDGE_DROP_CNT_EN defined:
//   - 16-bit drop_cnt counts dropped bytes, saturating at 0xFFFF.
//   - Readback chain W = RESULT_WIDTH+16; capture loads {drop_cnt, result}.
//   - drop_cnt is shifted out after the result bits.
//   - A host reading only RESULT_WIDTH bits is unaffected.
// - Undefined:
//   - W = RESULT_WIDTH; no counter; overflow flag only.
// TESTING
// - Single byte: scan 0x4C (LSB first), out_ready=1
//   -> one out_valid pulse, out_data=0x4C, overflow=0.
// - Readback: result=0x1234, 16-bit scan with tdi=0
//   -> tdo sequence LSB first reassembles 0x1234; FIFO unchanged (bit_cnt=16).
// - Fill: out_ready=0, scan FIFO_DEPTH+1 bytes 0x00..0x10
//   -> 16 entries 0x00..0x0F, overflow=1.
//   -> DROP_CNT_EN: a 32-bit readback shows upper half = 0x0001.
// - Full+pop: FIFO full, out_ready=1 in the update cycle of a new byte
//   -> accepted, occupancy stays 16, overflow stays 0.
// - Partial/gated: 5-bit scan, then an 8-bit scan with ir_is_user=0
//   -> no push, tdo=0 while gated.
// - Reset mid-scan: assert reset after 4 shifted bits, then scan a full 0xA5
//   -> out_data=0xA5 only; overflow=0.

Source files
------------

// File: rtl/jtag_dr_bridge.sv
// rtl/jtag_dr_bridge.sv - USER-IR DR endpoint: byte-per-scan ingest FIFO plus result readback (option: JTAG_DR_BRIDGE_DROP_CNT_EN)
module jtag_dr_bridge #(
  parameter int RESULT_WIDTH = 16,
  parameter int FIFO_DEPTH   = 16
) (
  input  logic                    tck,
  input  logic                    test_logic_reset_n,
  input  logic                    ir_is_user,
  input  logic                    capture_dr,
  input  logic                    shift_dr,
  input  logic                    update_dr,
  input  logic                    tdi,
  output logic                    tdo,
  input  logic [RESULT_WIDTH-1:0] result,
  output logic                    out_valid,
  output logic [7:0]              out_data,
  input  logic                    out_ready,
  output logic                    overflow
);

`ifdef JTAG_DR_BRIDGE_DROP_CNT_EN
  localparam int W = RESULT_WIDTH + 16;
`else
  localparam int W = RESULT_WIDTH;
`endif
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(FIFO_DEPTH);

  logic [7:0]    bit_cnt;
  logic [7:0]    byte_sr;
  logic [W-1:0]  rb_sr;
  logic [W-1:0]  rb_load;
  logic [7:0]    mem [FIFO_DEPTH];
  logic [AW:0]   wr_ptr;
  logic [AW:0]   rd_ptr;
  logic [AW:0]   count;
  logic          cap;
  logic          sh;
  logic          upd;
  logic          empty;
  logic          full;
  logic          pop;
  logic          push_req;
  logic          accept;
  logic          drop;

  // TAP controls only take effect while the USER instruction is selected
  assign cap = capture_dr & ir_is_user;
  assign sh  = shift_dr & ir_is_user;
  assign upd = update_dr & ir_is_user;

  // The extra pointer bit lets count reach FIFO_DEPTH, separating full from empty
  assign count    = wr_ptr - rd_ptr;
  assign empty    = (count == '0);
  assign full     = (count == FULL_CNT);
  assign pop      = ~empty & out_ready;
  // Only a scan of exactly 8 bits is a data byte; readback and aborted scans never push
  assign push_req = upd & (bit_cnt == 8'd8);
  assign accept   = push_req & (~full | pop);
  assign drop     = push_req & full & ~pop;

  assign out_valid = ~empty;
  assign out_data  = empty ? 8'h00 : mem[rd_ptr[AW-1:0]];
  // tdo comes straight from the readback register, so tdi never reaches it combinationally
  assign tdo       = ir_is_user & rb_sr[0];

`ifdef JTAG_DR_BRIDGE_DROP_CNT_EN
  logic [15:0] drop_cnt;

  // Saturating count of bytes lost to a full FIFO; read out above the result bits
  always_ff @(posedge tck) begin
    if (!test_logic_reset_n)
      drop_cnt <= '0;
    else if (drop && drop_cnt != 16'hFFFF)
      drop_cnt <= drop_cnt + 16'd1;
  end

  assign rb_load = {drop_cnt, result};
`else
  assign rb_load = result;
`endif

  // Scan chain: capture loads the readback word, shift moves both chains one bit
  always_ff @(posedge tck) begin
    if (!test_logic_reset_n) begin
      bit_cnt <= '0;
      byte_sr <= '0;
      rb_sr   <= '0;
    end else if (cap) begin
      rb_sr   <= rb_load;
      bit_cnt <= '0;
    end else if (sh) begin
      byte_sr <= {tdi, byte_sr[7:1]};
      rb_sr   <= {1'b0, rb_sr[W-1:1]};
      if (bit_cnt != 8'hFF)
        bit_cnt <= bit_cnt + 8'd1;
    end
  end

  // FIFO pointers and the sticky overflow flag
  always_ff @(posedge tck) begin
    if (!test_logic_reset_n) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      overflow <= 1'b0;
    end else begin
      if (accept)
        wr_ptr <= wr_ptr + 1'b1;
      if (pop)
        rd_ptr <= rd_ptr + 1'b1;
      if (drop)
        overflow <= 1'b1;
    end
  end

  // FIFO storage; contents are don't-care until written because out_data is masked while empty
  always_ff @(posedge tck) begin
    if (accept)
      mem[wr_ptr[AW-1:0]] <= byte_sr;
  end

endmodule

// File: tb/tb_jtag_dr_bridge.sv
// tb/tb_jtag_dr_bridge.sv - scoreboard bench for jtag_dr_bridge
module tb_jtag_dr_bridge;
  logic        tck = 1'b0;
  logic        test_logic_reset_n;
  logic        ir_is_user;
  logic        capture_dr;
  logic        shift_dr;
  logic        update_dr;
  logic        tdi;
  logic        tdo;
  logic [15:0] result;
  logic        out_valid;
  logic [7:0]  out_data;
  logic        out_ready;
  logic        overflow;

  int          errors = 0;
  int          checks = 0;
  int          pops   = 0;
  logic [7:0]  exp_q[$];
  logic [31:0] tw;
  int          p0;

  always #5 tck = ~tck;

  jtag_dr_bridge #(.RESULT_WIDTH(16), .FIFO_DEPTH(16)) dut (
    .tck(tck),
    .test_logic_reset_n(test_logic_reset_n),
    .ir_is_user(ir_is_user),
    .capture_dr(capture_dr),
    .shift_dr(shift_dr),
    .update_dr(update_dr),
    .tdi(tdi),
    .tdo(tdo),
    .result(result),
    .out_valid(out_valid),
    .out_data(out_data),
    .out_ready(out_ready),
    .overflow(overflow)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, req);
    end
  endtask

  // Monitor: every accepted pop is compared against the scoreboard head
  always @(negedge tck) begin
    if (test_logic_reset_n === 1'b1 && out_valid === 1'b1 && out_ready === 1'b1) begin
      pops++;
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_pop: got 0x%0h expected no output", out_data);
      end else begin
        check("pop_data", {24'h0, out_data}, {24'h0, exp_q.pop_front()});
      end
    end
  end

  task automatic cyc();
    @(posedge tck);
    #1;
  endtask

  task automatic do_reset();
    test_logic_reset_n = 1'b0;
    cyc();
    cyc();
    test_logic_reset_n = 1'b1;
  endtask

  // Capture, n shift cycles (tdo sampled before each shift edge), exit1, update
  task automatic scan(input logic [31:0] data, input int n, input logic user,
                      input logic pop_at_upd, output logic [31:0] tdo_word);
    tdo_word   = '0;
    ir_is_user = user;
    capture_dr = 1'b1;
    cyc();
    capture_dr = 1'b0;
    for (int i = 0; i < n; i++) begin
      shift_dr    = 1'b1;
      tdi         = data[i];
      tdo_word[i] = tdo;
      cyc();
    end
    shift_dr = 1'b0;
    tdi      = 1'b0;
    cyc();
    update_dr = 1'b1;
    if (pop_at_upd) out_ready = 1'b1;
    cyc();
    update_dr = 1'b0;
    if (pop_at_upd) out_ready = 1'b0;
    ir_is_user = 1'b1;
  endtask

  task automatic drain(input int expect_n);
    int start;
    start     = pops;
    out_ready = 1'b1;
    for (int k = 0; k < 200 && out_valid; k++) cyc();
    out_ready = 1'b0;
    check("drain_count", pops - start, expect_n);
    check("drain_empty", {31'h0, out_valid}, 32'h0);
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    test_logic_reset_n = 1'b0;
    ir_is_user = 1'b1;
    capture_dr = 1'b0;
    shift_dr   = 1'b0;
    update_dr  = 1'b0;
    tdi        = 1'b0;
    result     = 16'h0;
    out_ready  = 1'b0;
    do_reset();

    // Reset state
    check("rst_out_valid", {31'h0, out_valid}, 32'h0);
    check("rst_out_data", {24'h0, out_data}, 32'h0);
    check("rst_overflow", {31'h0, overflow}, 32'h0);
    check("rst_tdo", {31'h0, tdo}, 32'h0);

    // Single byte
    out_ready = 1'b1;
    p0 = pops;
    exp_q.push_back(8'h4C);
    scan(32'h4C, 8, 1'b1, 1'b0, tw);
    cyc();
    cyc();
    check("single_pulses", pops - p0, 1);
    check("single_valid_low", {31'h0, out_valid}, 32'h0);
    check("single_overflow", {31'h0, overflow}, 32'h0);
    out_ready = 1'b0;

    // Readback of result, no push for a 16-bit scan
    result = 16'h1234;
    scan(32'h0, 16, 1'b1, 1'b0, tw);
    check("readback_tdo", tw, 32'h1234);
    cyc();
    check("readback_no_push", {31'h0, out_valid}, 32'h0);

    // Fill with one extra byte -> overflow
    for (int b = 0; b <= 16; b++) begin
      if (b < 16) exp_q.push_back(8'(b));
      scan(32'(b), 8, 1'b1, 1'b0, tw);
    end
    check("fill_overflow", {31'h0, overflow}, 32'h1);
    check("fill_head", {24'h0, out_data}, 32'h0);
`ifdef JTAG_DR_BRIDGE_DROP_CNT_EN
    result = 16'hBEEF;
    scan(32'h0, 32, 1'b1, 1'b0, tw);
    check("drop_cnt_hi", {16'h0, tw[31:16]}, 32'h1);
    check("drop_cnt_lo", {16'h0, tw[15:0]}, 32'hBEEF);
`endif
    drain(16);
    check("overflow_sticky", {31'h0, overflow}, 32'h1);

    // Full with same-cycle pop: push accepted
    do_reset();
    check("rst2_overflow", {31'h0, overflow}, 32'h0);
    for (int b = 0; b < 16; b++) begin
      exp_q.push_back(8'(8'h20 + b));
      scan(32'(8'h20 + b), 8, 1'b1, 1'b0, tw);
    end
    exp_q.push_back(8'h30);
    scan(32'h30, 8, 1'b1, 1'b1, tw);
    check("fullpop_overflow", {31'h0, overflow}, 32'h0);
    check("fullpop_head", {24'h0, out_data}, 32'h21);
    drain(16);

    // Partial scan, then gated scan
    result = 16'hFFFF;
    scan(32'h0, 5, 1'b1, 1'b0, tw);
    scan(32'h5A, 8, 1'b0, 1'b0, tw);
    check("gated_tdo", tw, 32'h0);
    cyc();
    check("partial_gated_no_push", {31'h0, out_valid}, 32'h0);
    check("tdo_ungated", {31'h0, tdo}, 32'h1);

    // Reset in the middle of a scan
    capture_dr = 1'b1;
    cyc();
    capture_dr = 1'b0;
    for (int i = 0; i < 4; i++) begin
      shift_dr = 1'b1;
      tdi      = 1'b1;
      cyc();
    end
    test_logic_reset_n = 1'b0;
    cyc();
    test_logic_reset_n = 1'b1;
    shift_dr = 1'b0;
    tdi      = 1'b0;
    check("midrst_valid", {31'h0, out_valid}, 32'h0);
    check("midrst_tdo", {31'h0, tdo}, 32'h0);
    out_ready = 1'b1;
    p0 = pops;
    exp_q.push_back(8'hA5);
    scan(32'hA5, 8, 1'b1, 1'b0, tw);
    cyc();
    cyc();
    out_ready = 1'b0;
    check("midrst_pulses", pops - p0, 1);
    check("midrst_overflow", {31'h0, overflow}, 32'h0);

    check("scoreboard_empty", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
